// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Op encodings match the thirtytwoBitALU control field.
package alu_ctrl_pkg;

    localparam int unsigned REQ_N = 2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// The master side belongs to the requesters; the slave side belongs to the arbiter.
interface alu_arbiter_if;
    import alu_ctrl_pkg::*;

    logic [REQ_N-1:0] req_valid;
    logic [REQ_N-1:0] req_ready;
    logic [31:0]      req_a0;
    logic [31:0]      req_b0;
    logic [31:0]      req_a1;
    logic [31:0]      req_b1;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [REQ_N-1:0] rsp_valid;
    logic [REQ_N-1:0] rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_set;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_set
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_set
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: a lone requester wins, a tie goes to prio.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/thirtytwoBitALU.sv
// 32-bit ALU: AND, OR, ADD, SUB, signed SLT, with zero/overflow/set flags.
// Unknown op codes produce a zero result with overflow and set cleared.
module thirtytwoBitALU
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        set
);

    logic        sub;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        ovf;
    logic        lt;

    always_comb begin
        sub   = (op == OP_SUB) || (op == OP_SLT);
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + {31'b0, sub};
        // Signed overflow of the shared adder; SLT corrects the sign with it.
        ovf   = (a[31] == b_eff[31]) && (sum[31] != a[31]);
        lt    = sum[31] ^ ovf;

        result   = '0;
        overflow = 1'b0;
        set      = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD, OP_SUB: begin
                result   = sum;
                overflow = ovf;
            end
            OP_SLT: begin
                result = {31'b0, lt};
                set    = lt;
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one thirtytwoBitALU between two valid/ready requesters with round-robin grant.
// Operands are latched on grant; result and flags are registered and held until accepted.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    state_t state_q, state_d;

    logic [1:0]       grant;
    logic             gnt_idx;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [2:0]       op_q;
    logic             owner;
    logic             prio;
    logic [31:0]      rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_overflow_q;
    logic             rsp_set_q;
    logic [CNT_W-1:0] done_cnt_q [REQ_N];
    logic [REQ_N-1:0] req_ready;
    logic [REQ_N-1:0] rsp_valid;
    logic             rsp_fire;

    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_set;

    rr_arbiter2 u_arb (
        .valid (bus.req_valid),
        .prio  (prio),
        .grant (grant)
    );

    thirtytwoBitALU u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .set      (alu_set)
    );

    assign gnt_idx  = grant[1];
    assign rsp_fire = (state_q == RESP) && bus.rsp_ready[owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant != 2'b00) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE:    req_ready = grant;
            RESP:    rsp_valid[owner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            owner          <= 1'b0;
            prio           <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_set_q      <= 1'b0;
            done_cnt_q[0]  <= '0;
            done_cnt_q[1]  <= '0;
        end else begin
            if (state_q == IDLE && grant != 2'b00) begin
                a_q   <= gnt_idx ? bus.req_a1  : bus.req_a0;
                b_q   <= gnt_idx ? bus.req_b1  : bus.req_b0;
                op_q  <= gnt_idx ? bus.req_op1 : bus.req_op0;
                owner <= gnt_idx;
            end
            if (state_q == EXEC) begin
                rsp_result_q   <= alu_result;
                rsp_zero_q     <= alu_zero;
                rsp_overflow_q <= alu_overflow;
                rsp_set_q      <= alu_set;
            end
            // The requester just served drops to lower priority for the next tie.
            if (rsp_fire) begin
                done_cnt_q[owner] <= done_cnt_q[owner] + CNT_W'(1);
                prio              <= ~owner;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_set      = rsp_set_q;
    assign done_cnt0        = done_cnt_q[0];
    assign done_cnt1        = done_cnt_q[1];

endmodule
